mem_initiator: RTL
==================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width; address arithmetic wraps modulo 2^ADDR_W.
REQ-002 Parameter DATA_W, default 8, memory data width; data-pattern arithmetic wraps modulo 2^DATA_W.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port cmd_valid  input  1  command offered.
REQ-006 Port cmd_ready  output  1  block can accept a command.
REQ-007 Port cmd_wr  input  1  1 = write burst, 0 = read burst.
REQ-008 Port cmd_addr  input  ADDR_W  burst start address.
REQ-009 Port cmd_len  input  4  beat count minus one (1..16 beats).
REQ-010 Port cmd_wdata  input  DATA_W  write-pattern seed.
REQ-011 Port rsp_valid  output  1  read beat available.
REQ-012 Port rsp_ready  input  1  consumer accepts the read beat.
REQ-013 Port rsp_data  output  DATA_W  read beat data.
REQ-014 Port rsp_last  output  1  final beat of the read burst.
REQ-015 Port mem_en  output  1  memory access strobe.
REQ-016 Port mem_wr_en  output  1  memory write enable; meaningful only when mem_en=1.
REQ-017 Port mem_addr  output  ADDR_W  memory address.
REQ-018 Port mem_wdata  output  DATA_W  memory write data.
REQ-019 Port mem_rdata  input  DATA_W  memory read data; valid exactly one cycle after a read strobe.
REQ-020 Port busy  output  1  high whenever the state is not IDLE.
REQ-021 Port done  output  1  one-cycle pulse when a burst completes.

Function
REQ-022 The FSM SHALL have the states IDLE, WRITE, RD_REQ, RD_WAIT and RSP.
REQ-023 In IDLE, cmd_ready SHALL be 1; in every other state it SHALL be 0.
REQ-024 A command SHALL be accepted on the clk edge where cmd_valid=1 and cmd_ready=1; on acceptance the block latches the address, length, seed and direction, and clears the beat counter i to 0.
REQ-025 An accepted write SHALL move to WRITE; an accepted read SHALL move to RD_REQ.
REQ-026 WRITE behaviour:
  - one beat per cycle with mem_en=1, mem_wr_en=1, mem_addr=cmd_addr+i, mem_wdata=cmd_wdata+i;
  - after beat i=cmd_len, go to IDLE.
REQ-027 RD_REQ SHALL drive mem_en=1, mem_wr_en=0, mem_addr=cmd_addr+i for one cycle, then go to RD_WAIT.
REQ-028 RD_WAIT SHALL drive mem_en=0, register mem_rdata into rsp_data, and go to RSP.
REQ-029 RSP behaviour:
  - rsp_valid=1; rsp_last=1 when i=cmd_len;
  - rsp_data and rsp_last hold stable until rsp_ready=1;
  - on handshake: if last, go to IDLE; otherwise increment i and go to RD_REQ.
REQ-030 Minimum read throughput SHALL be one beat per 3 cycles; each cycle of rsp_ready=0 adds one cycle.
REQ-031 done SHALL pulse high for exactly the one cycle after the final write beat or the final rsp handshake.
REQ-032 mem_en SHALL be 0 in IDLE, RD_WAIT and RSP; rsp_valid SHALL be 0 outside RSP.
REQ-033 Address wrap SHALL occur without error, e.g. ADDR_W=4, cmd_addr=14, 4 beats gives addresses 14, 15, 0, 1.
REQ-034 Data-pattern wrap SHALL likewise occur, e.g. seed 8'hFF, 2 beats gives FF, 00.
REQ-035 A cmd_valid arriving while busy SHALL be ignored (not queued); it is accepted only once back in IDLE.
REQ-036 Back-to-back operation: a new command MAY be accepted on the first IDLE cycle, which is the same cycle done is high.

Reset
REQ-037 rst=1 at a clk edge SHALL force IDLE from any state, abandoning any burst in progress.
REQ-038 While rst=1 and on the cycle after it, outputs SHALL be:
  - cmd_ready=0 while rst=1;
  - mem_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0;
  - rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, done=0.
REQ-039 Reset mid-burst SHALL NOT produce a done pulse; no further memory strobes SHALL occur until a new command is accepted.

Verification
REQ-040 Write 4 beats at addr 2, seed 8'h10 -> mem writes (2,10),(3,11),(4,12),(5,13) on 4 consecutive cycles; done one cycle after; busy high throughout.
REQ-041 Read 4 beats at addr 2 after the REQ-040 write, rsp_ready=1 -> rsp_data 10,11,12,13 at 3-cycle spacing; rsp_last only on 13; done once.
REQ-042 Read 2 beats with rsp_ready held 0 for 5 cycles on beat 0 -> rsp_data stable during the stall; no mem strobe during the stall; second beat follows after release.
REQ-043 Write 3 beats at addr 15, seed 8'hFE -> addresses 15,0,1; data FE,FF,00.
REQ-044 Assert rst during beat 2 of an 8-beat read -> next cycle idle outputs per REQ-038; no done; a fresh command is accepted afterward.
REQ-045 cmd_valid held high during a burst with a different command -> ignored until IDLE, then accepted exactly once per handshake.

Source files
------------

// File: rtl/mem_initiator.sv
// Burst memory initiator: issues write bursts with an incrementing data pattern
// and read bursts returned one beat at a time over a valid/ready response port.
module mem_initiator #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_REQ,
    RD_WAIT,
    RSP
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [3:0]        beat_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;

  logic              accept;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_data;

  assign accept    = cmd_valid && cmd_ready;
  assign last_beat = (beat_q == len_q);
  assign beat_addr = addr_q + ADDR_W'(beat_q);
  assign beat_data = seed_q + DATA_W'(beat_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst direction is carried by the state itself, so no separate direction flop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = cmd_wr ? WRITE : RD_REQ;
        end
      end
      WRITE: begin
        if (last_beat) begin
          state_nxt = IDLE;
        end
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RSP;
      RSP: begin
        if (rsp_ready) begin
          state_nxt = last_beat ? IDLE : RD_REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            seed_q <= cmd_wdata;
            beat_q <= '0;
          end
        end
        WRITE: begin
          if (last_beat) begin
            done_q <= 1'b1;
          end else begin
            beat_q <= beat_q + 4'd1;
          end
        end
        RD_WAIT: rdata_q <= mem_rdata;
        RSP: begin
          if (rsp_ready) begin
            if (last_beat) begin
              done_q <= 1'b1;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced idle while rst is high, before the state register has
  // actually returned to IDLE.
  always_comb begin
    cmd_ready = 1'b0;
    mem_en    = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_data  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      busy     = (state != IDLE);
      done     = done_q;
      rsp_data = rdata_q;
      case (state)
        IDLE: cmd_ready = 1'b1;
        WRITE: begin
          mem_en    = 1'b1;
          mem_wr_en = 1'b1;
          mem_addr  = beat_addr;
          mem_wdata = beat_data;
        end
        RD_REQ: begin
          mem_en   = 1'b1;
          mem_addr = beat_addr;
        end
        RSP: begin
          rsp_valid = 1'b1;
          rsp_last  = last_beat;
        end
        default: ;
      endcase
    end
  end

endmodule
